// File: rtl/arithmetic_core.sv
// Single-PE 3x3 int8 MAC core: bias, multi-window accumulate,
// requantize to int8, optional ReLU and 4:1 max-pool.
module arithmetic_core (
   input  logic        clk,
   input  logic        reset,
   input  logic [71:0] in,
   input  logic [71:0] weight,
   input  logic [15:0] bias,
   input  logic [2:0]  bound_level,
   input  logic [2:0]  step,
   input  logic        en,
   input  logic        en_relu,
   input  logic        en_mp,
   output logic [7:0]  out,
   output logic        out_en
);

   logic signed [15:0] prod [9];
   logic signed [19:0] dot;
   logic signed [23:0] dot_x;
   logic signed [23:0] bias_x;
   logic signed [23:0] acc;
   logic [2:0]         scnt;
   logic               grp_done;

   logic [3:0]         shamt;
   logic signed [23:0] shifted;
   logic signed [7:0]  q_sat;
   logic signed [7:0]  r_nxt;
   logic signed [7:0]  r_q;
   logic               r_vld;

   logic [1:0]         pcnt;
   logic signed [7:0]  pmax;
   logic signed [7:0]  pool_nxt;

   always_comb begin
      dot = '0;
      for (int k = 0; k < 9; k++) begin
         prod[k] = $signed(in[71-8*k -: 8])
                 * $signed(weight[71-8*k -: 8]);
         dot = dot + {{4{prod[k][15]}}, prod[k]};
      end
   end

   assign dot_x  = {{4{dot[19]}}, dot};
   assign bias_x = {{8{bias[15]}}, bias};

   // Window accumulation; first window of a group reloads bias.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc      <= '0;
         scnt     <= '0;
         grp_done <= 1'b0;
      end else begin
         grp_done <= 1'b0;
         if (en) begin
            if (scnt == 3'd0) acc <= bias_x + dot_x;
            else              acc <= acc + dot_x;
            if (scnt == step) begin
               scnt     <= '0;
               grp_done <= 1'b1;
            end else begin
               scnt <= scnt + 3'd1;
            end
         end
      end
   end

   assign shamt   = 4'd11 - {1'b0, bound_level};
   assign shifted = acc >>> shamt;

   always_comb begin
      unique case (1'b1)
         (shifted > 24'sd127):  q_sat = 8'sd127;
         (shifted < -24'sd128): q_sat = -8'sd128;
         default:               q_sat = shifted[7:0];
      endcase
   end

   assign r_nxt = (en_relu && q_sat[7]) ? 8'sd0 : q_sat;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_q   <= '0;
         r_vld <= 1'b0;
      end else begin
         r_vld <= grp_done;
         if (grp_done) r_q <= r_nxt;
      end
   end

   // Pool window restarts on the first of every four results.
   assign pool_nxt = (pcnt == 2'd0 || r_q > pmax) ? r_q : pmax;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pcnt   <= '0;
         pmax   <= '0;
         out    <= '0;
         out_en <= 1'b0;
      end else begin
         out_en <= 1'b0;
         if (r_vld) begin
            if (!en_mp) begin
               out    <= r_q;
               out_en <= 1'b1;
            end else begin
               pmax <= pool_nxt;
               pcnt <= pcnt + 2'd1;
               if (pcnt == 2'd3) begin
                  out    <= pool_nxt;
                  out_en <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_arithmetic_core.sv
// Bench for arithmetic_core: directed and random windows
// checked against an integer reference model.
module tb_arithmetic_core;

   logic        clk = 1'b0;
   logic        reset;
   logic [71:0] din;
   logic [71:0] wt;
   logic [15:0] bias;
   logic [2:0]  bound_level;
   logic [2:0]  step;
   logic        en;
   logic        en_relu;
   logic        en_mp;
   logic [7:0]  out;
   logic        out_en;

   int checks = 0;
   int failures = 0;
   int edge_n = 0;
   int got_v[$];
   int got_e[$];
   int acc_e[$];
   logic [71:0] q_in[$];
   logic [71:0] q_w[$];
   logic [71:0] sv_in[$];
   logic [71:0] sv_w[$];

   arithmetic_core dut (
      .clk(clk),
      .reset(reset),
      .in(din),
      .weight(wt),
      .bias(bias),
      .bound_level(bound_level),
      .step(step),
      .en(en),
      .en_relu(en_relu),
      .en_mp(en_mp),
      .out(out),
      .out_en(out_en)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (reset === 1'b1 && out_en === 1'b1) begin
         got_v.push_back(int'($signed(out)));
         got_e.push_back(edge_n);
      end
   end

   task automatic tick;
      @(posedge clk);
      edge_n++;
      #1;
   endtask

   task automatic chk(string tag, int obs, int expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, expv);
      end
   endtask

   function automatic int dotp(logic [71:0] a, logic [71:0] b);
      int s = 0;
      for (int k = 0; k < 9; k++)
         s += int'($signed(a[71-8*k -: 8]))
            * int'($signed(b[71-8*k -: 8]));
      return s;
   endfunction

   function automatic int fdiv(int a, int d);
      int r = a / d;
      if ((a % d) != 0 && a < 0) r--;
      return r;
   endfunction

   function automatic int sat8(int x);
      if (x > 127) return 127;
      if (x < -128) return -128;
      return x;
   endfunction

   function automatic logic [71:0] rep(logic [7:0] b);
      return {9{b}};
   endfunction

   task automatic add_rep(int n, logic [7:0] a, logic [7:0] b);
      for (int i = 0; i < n; i++) begin
         q_in.push_back(rep(a));
         q_w.push_back(rep(b));
      end
   endtask

   task automatic add_rand(int n);
      logic [95:0] ta;
      logic [95:0] tb;
      for (int i = 0; i < n; i++) begin
         ta = {$urandom(), $urandom(), $urandom()};
         tb = {$urandom(), $urandom(), $urandom()};
         q_in.push_back(ta[71:0]);
         q_w.push_back(tb[71:0]);
      end
   endtask

   task automatic run(string tag, logic [15:0] b,
                      logic [2:0] bl, logic [2:0] st,
                      logic rl, logic mp, int gap);
      int gs, per, nexp, acc, q, m, last, w0;
      reset = 1'b0;
      en = 1'b0;
      bias = b;
      bound_level = bl;
      step = st;
      en_relu = rl;
      en_mp = mp;
      din = rep(8'h7f);
      wt = rep(8'h7f);
      tick();
      en = 1'b1;
      tick();
      tick();
      chk({tag, ":rst_out"}, int'(out), 0);
      chk({tag, ":rst_en"}, int'(out_en), 0);
      en = 1'b0;
      reset = 1'b1;
      tick();
      got_v.delete();
      got_e.delete();
      acc_e.delete();
      for (int i = 0; i < q_in.size(); i++) begin
         din = q_in[i];
         wt = q_w[i];
         en = 1'b1;
         tick();
         acc_e.push_back(edge_n);
         en = 1'b0;
         repeat (gap) tick();
      end
      repeat (6) tick();
      gs = int'(st) + 1;
      per = mp ? 4 : 1;
      nexp = q_in.size() / (gs * per);
      chk({tag, ":count"}, got_v.size(), nexp);
      m = 0;
      for (int j = 0; j < nexp; j++) begin
         m = -129;
         for (int c = 0; c < per; c++) begin
            acc = int'($signed(b));
            w0 = (j * per + c) * gs;
            for (int w = 0; w < gs; w++)
               acc += dotp(q_in[w0+w], q_w[w0+w]);
            q = sat8(fdiv(acc, 1 << (11 - int'(bl))));
            if (rl && q < 0) q = 0;
            if (q > m) m = q;
         end
         last = acc_e[(j + 1) * per * gs - 1];
         if (j < got_v.size()) begin
            chk($sformatf("%s:val%0d", tag, j), got_v[j], m);
            chk($sformatf("%s:edge%0d", tag, j), got_e[j], last + 2);
         end
      end
      if (nexp > 0)
         chk({tag, ":hold"}, int'($signed(out)), m);
      q_in.delete();
      q_w.delete();
   endtask

   initial begin
      reset = 1'b0;
      en = 1'b0;
      din = '0;
      wt = '0;
      bias = '0;
      bound_level = '0;
      step = '0;
      en_relu = 1'b0;
      en_mp = 1'b0;

      add_rep(64, 8'd1, 8'd16);
      run("ones", 16'd0, 3'd0, 3'd0, 1'b0, 1'b0, 0);

      add_rep(16, 8'd127, 8'd127);
      run("max70", 16'd0, 3'd0, 3'd0, 1'b0, 1'b0, 0);

      add_rep(4, 8'd127, 8'd127);
      run("satp", 16'd0, 3'd7, 3'd0, 1'b0, 1'b0, 0);

      add_rep(4, 8'd127, 8'h80);
      run("relu", 16'd0, 3'd7, 3'd0, 1'b1, 1'b0, 0);

      add_rep(4, 8'd127, 8'h80);
      run("satn", 16'd0, 3'd7, 3'd0, 1'b0, 1'b0, 0);

      q_in.push_back({8'd1, 64'd0});
      q_w.push_back({8'd48, 64'd0});
      q_in.push_back({8'd1, 64'd0});
      q_w.push_back({8'hb0, 64'd0});
      q_in.push_back({8'd2, 64'd0});
      q_w.push_back({8'd72, 64'd0});
      q_in.push_back({8'd1, 64'd0});
      q_w.push_back({8'd16, 64'd0});
      run("pool4", 16'd0, 3'd7, 3'd0, 1'b0, 1'b1, 0);

      add_rand(64);
      run("rpool", 16'($urandom()), 3'd7, 3'd0, 1'b0, 1'b1, 0);

      add_rand(64);
      sv_in = q_in;
      sv_w = q_w;
      run("racc4", 16'h0123, 3'd4, 3'd3, 1'b0, 1'b0, 0);

      q_in = sv_in;
      q_w = sv_w;
      run("gap", 16'h0123, 3'd4, 3'd3, 1'b0, 1'b0, 2);

      add_rand(64);
      run("racc2mp", 16'($urandom()), 3'd3, 3'd1, 1'b1, 1'b1, 0);

      add_rand(32);
      run("rstep7", 16'($urandom()), 3'd2, 3'd7, 1'b0, 1'b0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
